// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the read-side and write-side pointer blocks
// and by both pointer synchronisers of the dual-clock FIFO.
//   ADDR_SIZE_DEFAULT : default FIFO address width (depth = 2**ADDR_SIZE_DEFAULT)
//   ptr_max_t         : widest pointer the helpers below handle
//   bin2gray/gray2bin : width-agnostic code converters; callers zero-extend a
//                       narrower value into ptr_max_t and truncate the result.
package fifo_pkg;

  localparam int ADDR_SIZE_DEFAULT = 3;
  localparam int PTR_MAX_W         = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  // Zero-extension is harmless: the leading zeros stay zero in Gray code.
  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Log-step XOR prefix from the MSB down; leading zeros contribute nothing.
  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin = gray;
    for (int s = 1; s < PTR_MAX_W; s = s * 2) begin
      bin = bin ^ (bin >> s);
    end
    return bin;
  endfunction

endpackage

// File: rtl/read_pointer_empty_block_if.sv
// read_pointer_empty_block_if: read-side request/status bundle of the FIFO.
//   inputs to the block : read_increment_i, write_to_read_pointer_i (Gray,
//                         already in the read domain), read_underflow_clear_i
//   outputs of the block: read_address_o, read_pointer_o (Gray), read_empty_o,
//                         read_almost_empty_o, read_level_o, read_underflow_o
// The "slave" modport is the block's view; "master" is the requester's view.
interface read_pointer_empty_block_if #(
  parameter int ADDR_SIZE = fifo_pkg::ADDR_SIZE_DEFAULT
) ();

  logic                 read_increment_i;
  logic [ADDR_SIZE:0]   write_to_read_pointer_i;
  logic                 read_underflow_clear_i;
  logic [ADDR_SIZE-1:0] read_address_o;
  logic [ADDR_SIZE:0]   read_pointer_o;
  logic                 read_empty_o;
  logic                 read_almost_empty_o;
  logic [ADDR_SIZE:0]   read_level_o;
  logic                 read_underflow_o;

  modport master (
    output read_increment_i, write_to_read_pointer_i, read_underflow_clear_i,
    input  read_address_o, read_pointer_o, read_empty_o, read_almost_empty_o,
           read_level_o, read_underflow_o
  );

  modport slave (
    input  read_increment_i, write_to_read_pointer_i, read_underflow_clear_i,
    output read_address_o, read_pointer_o, read_empty_o, read_almost_empty_o,
           read_level_o, read_underflow_o
  );

endinterface

// File: rtl/read_pointer_empty_block_g2b.sv
// gray_to_binary_block: purely combinational Gray-to-binary converter.
//   gray_i : Gray-coded pointer (width bits)
//   bin_o  : equivalent binary pointer (width bits)
// Also used by the write-side level logic.
module gray_to_binary_block
  import fifo_pkg::*;
#(
  parameter int width = ADDR_SIZE_DEFAULT + 1
) (
  input  logic [width-1:0] gray_i,
  output logic [width-1:0] bin_o
);

  // Widen to the helper's width, convert, then keep the low bits.
  always_comb begin
    bin_o = width'(gray2bin(ptr_max_t'(gray_i)));
  end

endmodule

// File: rtl/read_pointer_empty_block.sv
// read_pointer_empty_block: read-domain pointer and status controller of the
// dual-clock FIFO.
//   read_clock_i   : read-domain clock
//   read_reset_n_i : asynchronous active-low reset
//   rd_bus (slave) : read request, synchronised Gray write pointer, underflow
//                    clear in; RAM address, Gray read pointer, empty,
//                    almost-empty, level and underflow out (all registered).
// Optional build macro READ_UNDERFLOW_FLAG_EN enables the sticky underflow
// flag; without it read_underflow_o is a constant 0 and no flop is built.
// Reads are blocked while empty in either build.
module read_pointer_empty_block
  import fifo_pkg::*;
#(
  parameter int addr_size              = ADDR_SIZE_DEFAULT,
  parameter int almost_empty_threshold = 1
) (
  input  logic                        read_clock_i,
  input  logic                        read_reset_n_i,
  read_pointer_empty_block_if.slave   rd_bus
);

  localparam int PTR_W = addr_size + 1;

  logic [PTR_W-1:0] bin_q, bin_d;
  logic [PTR_W-1:0] gray_q, gray_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] wbin_s;
  logic             empty_q, empty_d;
  logic             almost_empty_q, almost_empty_d;
  logic             read_accept_s;

  gray_to_binary_block #(.width(PTR_W)) u_wptr_g2b (
    .gray_i (rd_bus.write_to_read_pointer_i),
    .bin_o  (wbin_s)
  );

  // Next-state: status is computed from the post-read pointer so the last
  // word read flips empty on the same edge that accepts it.
  always_comb begin
    read_accept_s  = rd_bus.read_increment_i & ~empty_q;
    bin_d          = bin_q + {{(PTR_W-1){1'b0}}, read_accept_s};
    gray_d         = PTR_W'(bin2gray(ptr_max_t'(bin_d)));
    empty_d        = (gray_d == rd_bus.write_to_read_pointer_i);
    level_d        = wbin_s - bin_d;
    almost_empty_d = (level_d <= PTR_W'(almost_empty_threshold));
  end

  // Pointer and status registers.
  always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
    if (!read_reset_n_i) begin
      bin_q          <= {PTR_W{1'b0}};
      gray_q         <= {PTR_W{1'b0}};
      level_q        <= {PTR_W{1'b0}};
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
    end else begin
      bin_q          <= bin_d;
      gray_q         <= gray_d;
      level_q        <= level_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
    end
  end

`ifdef READ_UNDERFLOW_FLAG_EN
  logic underflow_q, underflow_d;

  // Sticky underflow: a new empty read outranks a simultaneous clear.
  always_comb begin
    underflow_d = (rd_bus.read_increment_i & empty_q) |
                  (underflow_q & ~rd_bus.read_underflow_clear_i);
  end

  // Underflow register.
  always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
    if (!read_reset_n_i) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
    end
  end

  assign rd_bus.read_underflow_o = underflow_q;
`else
  logic unused_underflow_clear_s;
  assign unused_underflow_clear_s = rd_bus.read_underflow_clear_i;
  assign rd_bus.read_underflow_o  = 1'b0;
`endif

  assign rd_bus.read_address_o      = bin_q[addr_size-1:0];
  assign rd_bus.read_pointer_o      = gray_q;
  assign rd_bus.read_empty_o        = empty_q;
  assign rd_bus.read_almost_empty_o = almost_empty_q;
  assign rd_bus.read_level_o        = level_q;

endmodule

// File: tb/tb_read_pointer_empty_block.sv
// Directed self-checking bench for read_pointer_empty_block (addr_size=3,
// almost_empty_threshold=1). Underflow expectations follow the same
// READ_UNDERFLOW_FLAG_EN macro as the design build.
module tb_read_pointer_empty_block;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  read_pointer_empty_block_if #(.ADDR_SIZE(3)) bus ();

  read_pointer_empty_block #(.addr_size(3), .almost_empty_threshold(1)) dut (
    .read_clock_i   (clk),
    .read_reset_n_i (rst_n),
    .rd_bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

`ifdef READ_UNDERFLOW_FLAG_EN
  localparam logic UF_ON = 1'b1;
`else
  localparam logic UF_ON = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.read_increment_i = 1'b0;
    bus.write_to_read_pointer_i = 4'b0000;
    bus.read_underflow_clear_i = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.read_empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0b want 1", bus.read_empty_o); end
    n_checks++; if (bus.read_almost_empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_aempty got %0b want 1", bus.read_almost_empty_o); end
    n_checks++; if (bus.read_level_o !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", bus.read_level_o); end
    n_checks++; if (bus.read_pointer_o !== 4'b0000) begin n_fail++; $display("FAIL reset_ptr got %b want 0000", bus.read_pointer_o); end
    n_checks++; if (bus.read_address_o !== 3'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", bus.read_address_o); end
    n_checks++; if (bus.read_underflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_uf got %0b want 0", bus.read_underflow_o); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_drain();
    logic [3:0] exp_level;
    bus.write_to_read_pointer_i = 4'b0111;  // Gray(5)
    tick();
    n_checks++; if (bus.read_empty_o !== 1'b0) begin n_fail++; $display("FAIL fill_empty got %0b want 0", bus.read_empty_o); end
    n_checks++; if (bus.read_level_o !== 4'd5) begin n_fail++; $display("FAIL fill_level got %0d want 5", bus.read_level_o); end
    n_checks++; if (bus.read_almost_empty_o !== 1'b0) begin n_fail++; $display("FAIL fill_aempty got %0b want 0", bus.read_almost_empty_o); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.read_address_o !== 3'(i)) begin n_fail++; $display("FAIL drain_addr[%0d] got %0d want %0d", i, bus.read_address_o, i); end
      bus.read_increment_i = 1'b1;
      tick();
      exp_level = 4'(4 - i);
      n_checks++; if (bus.read_level_o !== exp_level) begin n_fail++; $display("FAIL drain_level[%0d] got %0d want %0d", i, bus.read_level_o, exp_level); end
      n_checks++; if (bus.read_empty_o !== (i == 4)) begin n_fail++; $display("FAIL drain_empty[%0d] got %0b want %0b", i, bus.read_empty_o, (i == 4)); end
      n_checks++; if (bus.read_almost_empty_o !== (exp_level <= 4'd1)) begin n_fail++; $display("FAIL drain_aempty[%0d] got %0b want %0b", i, bus.read_almost_empty_o, (exp_level <= 4'd1)); end
      n_checks++; if (bus.read_pointer_o !== gray4(4'(i + 1))) begin n_fail++; $display("FAIL drain_ptr[%0d] got %b want %b", i, bus.read_pointer_o, gray4(4'(i + 1))); end
    end
    bus.read_increment_i = 1'b0;
  endtask

  task automatic test_underflow();
    // Starts empty with read pointer Gray(5) = 0111, address 5.
    bus.read_increment_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.read_pointer_o !== 4'b0111) begin n_fail++; $display("FAIL uf_ptr[%0d] got %b want 0111", i, bus.read_pointer_o); end
      n_checks++; if (bus.read_address_o !== 3'd5) begin n_fail++; $display("FAIL uf_addr[%0d] got %0d want 5", i, bus.read_address_o); end
      n_checks++; if (bus.read_underflow_o !== UF_ON) begin n_fail++; $display("FAIL uf_set[%0d] got %0b want %0b", i, bus.read_underflow_o, UF_ON); end
      n_checks++; if (bus.read_empty_o !== 1'b1) begin n_fail++; $display("FAIL uf_empty[%0d] got %0b want 1", i, bus.read_empty_o); end
    end
    bus.read_increment_i = 1'b0;
    tick();
    n_checks++; if (bus.read_underflow_o !== UF_ON) begin n_fail++; $display("FAIL uf_sticky got %0b want %0b", bus.read_underflow_o, UF_ON); end
    bus.read_underflow_clear_i = 1'b1;
    tick();
    n_checks++; if (bus.read_underflow_o !== 1'b0) begin n_fail++; $display("FAIL uf_clear got %0b want 0", bus.read_underflow_o); end
    bus.read_increment_i = 1'b1;
    tick();
    n_checks++; if (bus.read_underflow_o !== UF_ON) begin n_fail++; $display("FAIL uf_set_wins got %0b want %0b", bus.read_underflow_o, UF_ON); end
    bus.read_increment_i = 1'b0;
    bus.read_underflow_clear_i = 1'b0;
    tick();
  endtask

  task automatic test_midstream_reset();
    bus.write_to_read_pointer_i = 4'b0100;  // Gray(7): two words ahead of read pointer 5
    tick();
    n_checks++; if (bus.read_level_o !== 4'd2) begin n_fail++; $display("FAIL mr_level_pre got %0d want 2", bus.read_level_o); end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.read_empty_o !== 1'b1) begin n_fail++; $display("FAIL mr_empty got %0b want 1", bus.read_empty_o); end
    n_checks++; if (bus.read_almost_empty_o !== 1'b1) begin n_fail++; $display("FAIL mr_aempty got %0b want 1", bus.read_almost_empty_o); end
    n_checks++; if (bus.read_level_o !== 4'd0) begin n_fail++; $display("FAIL mr_level got %0d want 0", bus.read_level_o); end
    n_checks++; if (bus.read_pointer_o !== 4'b0000) begin n_fail++; $display("FAIL mr_ptr got %b want 0000", bus.read_pointer_o); end
    n_checks++; if (bus.read_address_o !== 3'd0) begin n_fail++; $display("FAIL mr_addr got %0d want 0", bus.read_address_o); end
    n_checks++; if (bus.read_underflow_o !== 1'b0) begin n_fail++; $display("FAIL mr_uf got %0b want 0", bus.read_underflow_o); end
    bus.read_increment_i = 1'b1;
    tick();
    n_checks++; if (bus.read_pointer_o !== 4'b0000) begin n_fail++; $display("FAIL mr_no_read got %b want 0000", bus.read_pointer_o); end
    bus.read_increment_i = 1'b0;
    bus.write_to_read_pointer_i = 4'b0000;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_wrap();
    logic [3:0] wcount;
    logic [3:0] rcount;
    logic [3:0] prev_ptr;
    wcount = 4'd8;
    rcount = 4'd0;
    bus.write_to_read_pointer_i = gray4(wcount);  // 1100
    tick();
    n_checks++; if (bus.read_level_o !== 4'd8) begin n_fail++; $display("FAIL full_level got %0d want 8", bus.read_level_o); end
    n_checks++; if (bus.read_empty_o !== 1'b0) begin n_fail++; $display("FAIL full_empty got %0b want 0", bus.read_empty_o); end
    for (int i = 0; i < 16; i++) begin
      prev_ptr = bus.read_pointer_o;
      wcount = wcount + 4'd1;
      rcount = rcount + 4'd1;
      bus.read_increment_i = 1'b1;
      bus.write_to_read_pointer_i = gray4(wcount);
      tick();
      n_checks++; if (bus.read_pointer_o !== gray4(rcount)) begin n_fail++; $display("FAIL wrap_ptr[%0d] got %b want %b", i, bus.read_pointer_o, gray4(rcount)); end
      n_checks++; if ($countones(bus.read_pointer_o ^ prev_ptr) != 1) begin n_fail++; $display("FAIL wrap_onebit[%0d] got %b->%b want one bit change", i, prev_ptr, bus.read_pointer_o); end
      n_checks++; if (bus.read_address_o !== rcount[2:0]) begin n_fail++; $display("FAIL wrap_addr[%0d] got %0d want %0d", i, bus.read_address_o, rcount[2:0]); end
      n_checks++; if (bus.read_level_o !== 4'd8) begin n_fail++; $display("FAIL wrap_level[%0d] got %0d want 8", i, bus.read_level_o); end
    end
    n_checks++; if (bus.read_pointer_o !== 4'b0000) begin n_fail++; $display("FAIL wrap_end_ptr got %b want 0000", bus.read_pointer_o); end
    bus.read_increment_i = 1'b0;
  endtask

  task automatic test_simultaneous();
    rst_n = 1'b0;
    bus.write_to_read_pointer_i = 4'b0000;
    tick();
    rst_n = 1'b1;
    bus.write_to_read_pointer_i = 4'b0001;  // Gray(1)
    tick();
    n_checks++; if (bus.read_level_o !== 4'd1) begin n_fail++; $display("FAIL sim_level_pre got %0d want 1", bus.read_level_o); end
    n_checks++; if (bus.read_almost_empty_o !== 1'b1) begin n_fail++; $display("FAIL sim_aempty_pre got %0b want 1", bus.read_almost_empty_o); end
    bus.read_increment_i = 1'b1;
    bus.write_to_read_pointer_i = 4'b0011;  // Gray(2)
    tick();
    bus.read_increment_i = 1'b0;
    n_checks++; if (bus.read_empty_o !== 1'b0) begin n_fail++; $display("FAIL sim_empty got %0b want 0", bus.read_empty_o); end
    n_checks++; if (bus.read_level_o !== 4'd1) begin n_fail++; $display("FAIL sim_level got %0d want 1", bus.read_level_o); end
    n_checks++; if (bus.read_address_o !== 3'd1) begin n_fail++; $display("FAIL sim_addr got %0d want 1", bus.read_address_o); end
    n_checks++; if (bus.read_pointer_o !== 4'b0001) begin n_fail++; $display("FAIL sim_ptr got %b want 0001", bus.read_pointer_o); end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_drain();
    test_underflow();
    test_midstream_reset();
    test_full_wrap();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
